// File: rtl/fpga_input_debouncer.sv
// Purpose: debounces NUM_CH asynchronous board inputs. Each input is synchronized,
//          then accepted only after STABLE_TICKS consecutive sample ticks of mismatch.
// Latency: 2 sync cycles + (STABLE_TICKS-1)*TICK_DIV + k + 1 cycles (1 <= k <= TICK_DIV).
// Backpressure: none; db_o/rise_o/fall_o/tick_o are free-running level/strobe outputs.
//
// Ports:
//   clk_i   single clock, all state on its rising edge
//   rst_i   asynchronous, active-high reset
//   en_i    debounce enable; when low the prescaler and counters are parked, db_o holds
//   raw_i   asynchronous board inputs
//   db_o    debounced levels (registered)
//   rise_o  one-cycle pulse when db_o goes 0->1, coincident with the new db_o value
//   fall_o  one-cycle pulse when db_o goes 1->0, coincident with the new db_o value
//   tick_o  one-cycle sample-tick strobe
module fpga_input_debouncer #(
    parameter int                NUM_CH       = 7,
    parameter int                TICK_DIV     = 200000,
    parameter int                STABLE_TICKS = 10,
    parameter logic [NUM_CH-1:0] RESET_VAL    = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] db_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              tick_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [NUM_CH-1:0] meta;
    logic [NUM_CH-1:0] sync;
    logic [PW-1:0]     presc;
    logic [CW-1:0]     cnt [NUM_CH];

    // Two-flop synchronizer. It keeps sampling while en_i is low so that the
    // debounce restarts from the current pad level when enabled again.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
        end else begin
            meta <= raw_i;
            sync <= meta;
        end
    end

    // Prescaler parks at 0 while disabled, so the first tick after enabling
    // is always a full TICK_DIV period away.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc <= '0;
        end else if (!en_i) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Since presc is 0 in reset and TICK_DIV >= 2, tick_o is 0 during reset.
    assign tick_o = en_i && (presc == PRESC_LAST);

    // Per-channel stability counters. Any cycle in which the synchronized input
    // agrees with db_o (or the block is disabled) discards the partial count, so
    // only an uninterrupted mismatch spanning STABLE_TICKS ticks is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_o   <= RESET_VAL;
            rise_o <= '0;
            fall_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise_o <= '0;
            fall_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en_i || (sync[i] == db_o[i])) begin
                    cnt[i] <= '0;
                end else if (tick_o) begin
                    if (cnt[i] == CNT_LAST) begin
                        // Edge pulses are registered alongside db_o so they
                        // appear in the same cycle as the new level.
                        db_o[i]   <= sync[i];
                        rise_o[i] <= sync[i];
                        fall_o[i] <= ~sync[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fpga_input_debouncer.sv
// Purpose: self-checking bench for fpga_input_debouncer (TICK_DIV=4, STABLE_TICKS=3, NUM_CH=2).
// Latency: expected outputs are queued per cycle and compared at the following falling edge.
// Backpressure: none; the monitor pops one expectation per cycle.
module tb_fpga_input_debouncer;

    localparam int NCH = 2;
    localparam int TD  = 4;
    localparam int ST  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] db;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic           tick;

    always #5 clk = ~clk;

    fpga_input_debouncer #(
        .NUM_CH      (NCH),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .RESET_VAL   ('0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .raw_i (raw),
        .db_o  (db),
        .rise_o(rise),
        .fall_o(fall),
        .tick_o(tick)
    );

    typedef struct packed {
        logic [NCH-1:0] db;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic           tick;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state. Inputs are described per clock cycle; the model
    // derives sync as the input seen two cycles earlier, the tick schedule from
    // the length of the current enabled run, and accepts a level once a mismatch
    // has persisted through ST ticks.
    logic [NCH-1:0] m_db   = '0;
    logic [NCH-1:0] m_rise = '0;
    logic [NCH-1:0] m_fall = '0;
    int             ticks_in_mismatch [NCH];
    int             en_run = 0;

    logic           p_rst  = 1'b1;
    logic           p_en   = 1'b0;
    logic           p_tick = 1'b0;
    logic [NCH-1:0] p_raw  = '0;
    logic [NCH-1:0] p_sync = '0;
    logic [NCH-1:0] h1_raw = '0;
    logic [NCH-1:0] h2_raw = '0;
    logic           h1_rst = 1'b1;
    logic           h2_rst = 1'b1;

    // Clock edge: resolve the cycle that just ended.
    task automatic model_edge();
        m_rise = '0;
        m_fall = '0;
        if (!p_rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!p_en || (p_sync[ch] == m_db[ch])) begin
                    ticks_in_mismatch[ch] = 0;
                end else if (p_tick) begin
                    ticks_in_mismatch[ch] = ticks_in_mismatch[ch] + 1;
                    if (ticks_in_mismatch[ch] == ST) begin
                        m_db[ch]              = p_sync[ch];
                        m_rise[ch]            = p_sync[ch];
                        m_fall[ch]            = !p_sync[ch];
                        ticks_in_mismatch[ch] = 0;
                    end
                end
            end
        end
        en_run = (p_en && !p_rst) ? en_run + 1 : 0;
        h2_raw = h1_raw;
        h2_rst = h1_rst;
        h1_raw = p_raw;
        h1_rst = p_rst;
    endtask

    // New cycle: inputs just applied; queue the outputs expected in this cycle.
    task automatic model_cycle();
        exp_t           e;
        logic [NCH-1:0] s;
        logic           t;
        if (rst) begin
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            en_run = 0;
            for (int ch = 0; ch < NCH; ch++) ticks_in_mismatch[ch] = 0;
        end
        s = (rst || h1_rst || h2_rst) ? '0 : h2_raw;
        t = en && !rst && ((en_run % TD) == TD - 1);
        e.db   = m_db;
        e.rise = m_rise;
        e.fall = m_fall;
        e.tick = t;
        sb.push_back(e);
        p_rst  = rst;
        p_en   = en;
        p_raw  = raw;
        p_sync = s;
        p_tick = t;
    endtask

    task automatic step(input logic r, input logic e, input logic [NCH-1:0] rw);
        @(posedge clk);
        model_edge();
        #1;
        rst = r;
        en  = e;
        raw = rw;
        model_cycle();
    endtask

    task automatic hold(input logic e, input logic [NCH-1:0] rw, input int n);
        for (int i = 0; i < n; i++) step(1'b0, e, rw);
    endtask

    // Monitor: one expectation per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({db, rise, fall, tick} !== e) begin
                miscompares++;
                $display("FAIL vec%0d @%0t: got db=%b rise=%b fall=%b tick=%b, expected db=%b rise=%b fall=%b tick=%b",
                         vectors, $time, db, rise, fall, tick, e.db, e.rise, e.fall, e.tick);
            end
        end
    end

    initial begin
        for (int ch = 0; ch < NCH; ch++) ticks_in_mismatch[ch] = 0;
        rst = 1'b1;
        en  = 1'b0;
        raw = '0;

        // Reset, then idle with both inputs low: ticks every 4th cycle, no pulses.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00);
        hold(1'b1, 2'b00, 12);

        // Channel 0 rises and is held.
        hold(1'b1, 2'b01, 20);

        // Channel 1 chatters 3 high / 3 low: never accepted.
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, 2'b11, 3);
            hold(1'b1, 2'b01, 3);
        end

        // Settle at 11, then both fall in the same cycle.
        hold(1'b1, 2'b11, 20);
        hold(1'b1, 2'b00, 20);

        // Input changes while disabled; full re-count after enabling.
        hold(1'b0, 2'b01, 20);
        hold(1'b1, 2'b01, 20);

        // Reset in the middle of a count discards it; fresh count afterwards.
        hold(1'b1, 2'b00, 20);
        hold(1'b1, 2'b01, 9);
        step(1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b1, 2'b01);
        hold(1'b1, 2'b01, 20);

        // Randomized segments: random levels, lengths, occasional disable/reset.
        for (int seg = 0; seg < 60; seg++) begin
            logic [NCH-1:0] rw;
            logic           e;
            int             len;
            rw  = NCH'($urandom_range(0, 3));
            e   = ($urandom_range(0, 7) != 0);
            len = $urandom_range(1, 20);
            if ($urandom_range(0, 19) == 0) begin
                step(1'b1, e, rw);
            end
            hold(e, rw, len);
        end

        hold(1'b1, 2'b00, 4);
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
